// File: rtl/time_set_counter.sv
// Editable six-field RTC time/date register bank with a sequential req/ack write-out.
// Optional build macro DAY_LIMIT_EN: month/leap-year aware day limit with clamping.
module time_set_counter #(
    parameter int FIELDS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       edit_en,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       commit,
    input  logic       wr_ack,
    output logic [7:0] number,
    output logic [2:0] field,
    output logic       wr_req,
    output logic       busy,
    output logic [1:0] o_dbg_state
);

    // Handshake: a field transfers on every rising edge where wr_req and wr_ack
    // are both high; wr_req never drops mid-sequence and number/field hold until then.

    localparam logic [2:0] F_SEC   = 3'd0;
    localparam logic [2:0] F_MIN   = 3'd1;
    localparam logic [2:0] F_HOUR  = 3'd2;
    localparam logic [2:0] F_DAY   = 3'd3;
    localparam logic [2:0] F_MONTH = 3'd4;
    localparam logic [2:0] F_YEAR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EDIT  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t     r_state;
    logic [6:0] r_val [FIELDS];
    logic [2:0] r_field;
    logic       r_wr_req;
    logic       r_busy;

    logic [6:0] w_cur;
    logic [6:0] w_min;
    logic [6:0] w_max;
    logic [6:0] w_stepped;
    logic [6:0] w_dmax_cur;
    logic [6:0] w_nxt_val [FIELDS];
    logic [2:0] w_field_nxt;
    logic       w_inc;
    logic       w_dec;
    logic       w_ack;

    // Minimum of each field; doubles as its reset value.
    function automatic logic [6:0] field_min(input logic [2:0] idx);
        return (idx == F_DAY || idx == F_MONTH) ? 7'd1 : 7'd0;
    endfunction

    function automatic logic [6:0] field_max(input logic [2:0] idx, input logic [6:0] dmax);
        case (idx)
            F_SEC, F_MIN: return 7'd59;
            F_HOUR:       return 7'd23;
            F_DAY:        return dmax;
            F_MONTH:      return 7'd12;
            default:      return 7'd99;
        endcase
    endfunction

`ifdef DAY_LIMIT_EN
    logic [6:0] w_dmax_nxt;

    function automatic logic [6:0] day_max(input logic [6:0] month, input logic [6:0] year);
        case (month)
            7'd2:                    return ((year % 7'd4) == 7'd0) ? 7'd29 : 7'd28;
            7'd4, 7'd6, 7'd9, 7'd11: return 7'd30;
            default:                 return 7'd31;
        endcase
    endfunction

    assign w_dmax_cur = day_max(r_val[F_MONTH], r_val[F_YEAR]);
`else
    assign w_dmax_cur = 7'd31;
`endif

    always_comb begin
        w_cur = r_val[0];
        for (int i = 0; i < FIELDS; i++) begin
            if (r_field == 3'(i)) w_cur = r_val[i];
        end
    end

    assign w_inc = btn_up & ~btn_down;
    assign w_dec = btn_down & ~btn_up;
    assign w_min = field_min(r_field);
    assign w_max = field_max(r_field, w_dmax_cur);
    assign w_ack = r_wr_req & wr_ack;

    always_comb begin
        w_stepped = w_cur;
        if (w_inc) w_stepped = (w_cur >= w_max) ? w_min : w_cur + 7'd1;
        if (w_dec) w_stepped = (w_cur <= w_min) ? w_max : w_cur - 7'd1;
    end

    always_comb begin
        for (int i = 0; i < FIELDS; i++) begin
            w_nxt_val[i] = (r_field == 3'(i)) ? w_stepped : r_val[i];
        end
`ifdef DAY_LIMIT_EN
        // A month/year change can shrink the day limit below the stored day.
        w_dmax_nxt = day_max(w_nxt_val[F_MONTH], w_nxt_val[F_YEAR]);
        if (w_nxt_val[F_DAY] > w_dmax_nxt) w_nxt_val[F_DAY] = w_dmax_nxt;
`endif
    end

    always_comb begin
        w_field_nxt = r_field;
        if (btn_right && !btn_left) w_field_nxt = (r_field == F_YEAR) ? F_SEC : r_field + 3'd1;
        if (btn_left && !btn_right) w_field_nxt = (r_field == F_SEC) ? F_YEAR : r_field - 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_field  <= F_SEC;
            r_wr_req <= 1'b0;
            r_busy   <= 1'b0;
            for (int i = 0; i < FIELDS; i++) r_val[i] <= field_min(3'(i));
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (commit) begin
                        r_state  <= ST_WRITE;
                        r_field  <= F_SEC;
                        r_wr_req <= 1'b1;
                        r_busy   <= 1'b1;
                    end else if (edit_en) begin
                        r_state <= ST_EDIT;
                    end
                end
                ST_EDIT: begin
                    if (commit) begin
                        r_state  <= ST_WRITE;
                        r_field  <= F_SEC;
                        r_wr_req <= 1'b1;
                        r_busy   <= 1'b1;
                    end else if (!edit_en) begin
                        r_state <= ST_IDLE;
                    end else begin
                        for (int i = 0; i < FIELDS; i++) r_val[i] <= w_nxt_val[i];
                        r_field <= w_field_nxt;
                    end
                end
                ST_WRITE: begin
                    if (w_ack) begin
                        if (r_field == F_YEAR) begin
                            r_wr_req <= 1'b0;
                            r_busy   <= 1'b0;
                            r_field  <= F_SEC;
                            r_state  <= edit_en ? ST_EDIT : ST_IDLE;
                        end else begin
                            r_field <= r_field + 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign number      = {1'b0, w_cur};
    assign field       = r_field;
    assign wr_req      = r_wr_req;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_time_set_counter.sv
// Self-checking bench for time_set_counter: directed plan steps plus random
// button traffic against a field-arithmetic reference model.
module tb_time_set_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       edit_en;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       commit;
    logic       wr_ack;
    logic [7:0] number;
    logic [2:0] field;
    logic       wr_req;
    logic       busy;
    logic [1:0] dbg_state;

    int          checks = 0;
    int          errors = 0;
    int          m_val [6];
    int          m_field;
    bit          m_edit;
    logic [31:0] exp_q [$];

`ifdef DAY_LIMIT_EN
    localparam int EXP_FEB_LEAP = 29;
    localparam int EXP_FEB_NORM = 28;
`else
    localparam int EXP_FEB_LEAP = 31;
    localparam int EXP_FEB_NORM = 31;
`endif

    time_set_counter #(.FIELDS(6)) dut (
        .clk(clk), .rst_n(rst_n), .edit_en(edit_en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .commit(commit), .wr_ack(wr_ack),
        .number(number), .field(field), .wr_req(wr_req), .busy(busy),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int m_dmax();
`ifdef DAY_LIMIT_EN
        if (m_val[4] == 2) return (m_val[5] % 4 == 0) ? 29 : 28;
        if (m_val[4] == 4 || m_val[4] == 6 || m_val[4] == 9 || m_val[4] == 11) return 30;
`endif
        return 31;
    endfunction

    function automatic int m_lo(input int i);
        return (i == 3 || i == 4) ? 1 : 0;
    endfunction

    function automatic int m_hi(input int i);
        case (i)
            0, 1:    return 59;
            2:       return 23;
            3:       return m_dmax();
            4:       return 12;
            default: return 99;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 6; i++) m_val[i] = m_lo(i);
        m_field = 0;
        m_edit  = 1'b0;
    endtask

    task automatic clear_btns();
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; commit = 1'b0;
    endtask

    // One clock with the given button pulses; model updated from the field rules.
    task automatic cycle(input bit up, input bit dn, input bit lf, input bit rt);
        int lo;
        int span;
        btn_up = up; btn_down = dn; btn_left = lf; btn_right = rt;
        if (m_edit && edit_en) begin
            if (up != dn) begin
                lo   = m_lo(m_field);
                span = m_hi(m_field) - lo + 1;
                m_val[m_field] = lo + ((m_val[m_field] - lo + (up ? 1 : span - 1)) % span);
                if (m_val[3] > m_dmax()) m_val[3] = m_dmax();
            end
            if (lf != rt) m_field = (m_field + (rt ? 1 : 5)) % 6;
        end
        m_edit = edit_en;
        @(posedge clk); #1;
        clear_btns();
        chk("field", field, m_field);
        chk("number", number, m_val[m_field]);
        chk("idle_wr_req", wr_req, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic set_field(input int idx, input int target);
        for (int s = 0; s < 6 && m_field != idx; s++) cycle(0, 0, 0, 1);
        for (int s = 0; s < 100 && m_val[idx] != target; s++) cycle(1, 0, 0, 0);
    endtask

    // Commit (with value/select buttons in the same cycle) and ack each field after wait_n cycles.
    task automatic do_write(input int wait_n);
        int          n;
        logic [31:0] cur;
        logic [1:0]  st_wr;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(m_val[i]);
        commit = 1'b1; btn_up = 1'b1; btn_right = 1'b1;
        @(posedge clk); #1;
        clear_btns();
        st_wr = dbg_state;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (wr_req !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (k == 0) chk("commit_latency", n, 0);
            chk("wr_req_high", wr_req, 1);
            chk("wr_busy", busy, 1);
            chk("wr_field", field, k);
            cur = exp_q.pop_front();
            chk("wr_number", number, cur);
            for (int w = 0; w < wait_n; w++) begin
                btn_up = 1'($urandom_range(0, 1)); btn_down = 1'($urandom_range(0, 1));
                btn_left = 1'($urandom_range(0, 1)); btn_right = 1'($urandom_range(0, 1));
                commit = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                clear_btns();
                chk("hold_number", number, cur);
                chk("hold_field", field, k);
                chk("hold_req", wr_req, 1);
            end
            wr_ack = 1'b1;
            @(posedge clk); #1;
            wr_ack = 1'b0;
        end
        chk("wr_done_busy", busy, 0);
        chk("wr_done_req", wr_req, 0);
        chk("wr_done_field", field, 0);
        chk("dbg_state_distinct", (st_wr !== dbg_state) ? 1 : 0, 1);
        m_field = 0;
        m_edit  = edit_en;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; edit_en = 1'b0; wr_ack = 1'b0;
        clear_btns();
        m_reset();

        // Reset values, then release.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_number", number, 0);
        chk("rst_field", field, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        cycle(1, 0, 0, 0);
        edit_en = 1'b1;
        cycle(1, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 1);
        chk("tp_field3", field, 3);
        chk("tp_day_reset", number, 1);

        // Wrap on hour and field select.
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        chk("hour_down_wrap", number, 23);
        cycle(1, 0, 0, 0);
        chk("hour_up_wrap", number, 0);
        cycle(0, 1, 0, 0);
        chk("hour_23", number, 23);
        repeat (4) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        chk("field_left_wrap", field, 5);

        // Commit handshake with acks after 2 wait cycles; commit beats btn_up.
        set_field(0, 7);
        set_field(1, 30);
        set_field(2, 12);
        set_field(3, 15);
        set_field(4, 6);
        set_field(5, 24);
        do_write(2);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
        chk("sec_unchanged", number, 7);

        // Simultaneous opposing buttons; value + select together.
        cycle(1, 1, 0, 0);
        chk("updown_nochange", number, 7);
        cycle(0, 0, 1, 1);
        chk("leftright_nochange", field, 0);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 1, 0);
        chk("value_then_select", number, 8);

        // wr_ack tied high: six cycles of busy; stray ack before commit ignored.
        wr_ack = 1'b1; commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        wr_ack = 1'b0;
        chk("tied_ack_cycles", n, 6);
        m_field = 0;
        m_edit  = edit_en;
        cycle(0, 0, 0, 0);

        // Reset asserted while field 2 is being written.
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0; wr_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wr_ack = 1'b0;
        chk("mid_field", field, 2);
        chk("mid_number", number, m_val[2]);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_number", number, 0);
        chk("mid_rst_field", field, 0);
        chk("mid_rst_wr_req", wr_req, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        cycle(1, 0, 0, 0);

        // Day limit against month/year.
        set_field(3, 31);
        set_field(4, 2);
        cycle(0, 0, 1, 0);
        chk("feb_day_year0", number, EXP_FEB_LEAP);
        set_field(5, 1);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("feb_day_year1", number, EXP_FEB_NORM);
        cycle(1, 0, 0, 0);
        chk("day_up_wrap", number, 1);

        // Random button traffic with occasional edit_en drops.
        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 24) == 0) edit_en = ~edit_en;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        end
        edit_en = 1'b1;
        cycle(0, 0, 0, 0);
        do_write(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_counter.md
# time_set_counter

Editable calendar/time register bank that holds the six user-settable RTC fields in binary and presents them one at a time on an 8-bit bus to the binary-to-BCD converter directly downstream. Debounced push-button pulses select a field and step it up or down with per-field wrap-around. A commit request streams all six fields, seconds first, to the RTC write path through a req/ack handshake.

## Interface
Parameters:
- `FIELDS`, 6: number of fields, fixed; index 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year.

Ports:
- `clk` in 1: single system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `edit_en` in 1: high enables editing; low freezes all field values.
- `btn_up` in 1: single-cycle pulse; increment the selected field.
- `btn_down` in 1: single-cycle pulse; decrement the selected field.
- `btn_left` in 1: single-cycle pulse; select the previous field.
- `btn_right` in 1: single-cycle pulse; select the next field.
- `commit` in 1: single-cycle pulse; start a write sequence of all six fields.
- `wr_ack` in 1: downstream has accepted the current field.
- `number` out 8: binary value of field `field`; feeds the BCD converter.
- `field` out 3: field index currently shown or being written, 0..5.
- `wr_req` out 1: write request for field `field`.
- `busy` out 1: write sequence in progress.

## Operation
- Field ranges: sec 0..59, min 0..59, hour 0..23, day 1..31, month 1..12, year 0..99 (year 2000+year).
- `number` is a combinational mux of the field register selected by `field`. Its upper bits are zero-extended.
- States are IDLE, EDIT and WRITE.
- IDLE:
  - Entered while `edit_en` is low.
  - Buttons are ignored.
  - `commit` is accepted and goes to WRITE.
- EDIT:
  - Entered from IDLE when `edit_en` is high.
  - Returns to IDLE when `edit_en` falls.
- Button behaviour in EDIT:
  - `btn_up` on the max value wraps to the min value.
  - `btn_down` on the min value wraps to the max value.
  - `btn_right` steps `field` 5→0.
  - `btn_left` steps `field` 0→5.
- Simultaneous events in EDIT:
  - `commit` has priority over all buttons in the same cycle; the buttons are dropped.
  - `btn_up` and `btn_down` together: no change.
  - `btn_left` and `btn_right` together: no change.
  - A value button and a select button together: the value change applies to the old field, then the field select moves.
- WRITE:
  - Set `field`=0, `busy`=1, `wr_req`=1.
  - When `wr_ack` is high with `wr_req` high, advance `field` by one; `wr_req` stays high with no bubble.
  - Ack on field 5: `wr_req`=0, `busy`=0, `field`=0; return to EDIT if `edit_en` is high, else IDLE.
- Ignored inputs:
  - All buttons and `commit` are ignored while `busy`.
  - `wr_ack` is ignored when `wr_req` is low.
  - Dropping `edit_en` during WRITE does not abort the sequence.
- Field values are constant during WRITE, so `number` is stable while `wr_req` is high.

## Timing
- Reset values: sec 0, min 0, hour 0, day 1, month 1, year 0; `field` 0, `number` 0x00, `wr_req` 0, `busy` 0; state IDLE.
- Reset asserted mid-sequence clears everything to the values above immediately. No partial-write recovery.
- Button effect is visible on `number`/`field` the cycle after the pulse.
- `commit` at edge N gives `wr_req`=`busy`=1 from edge N+1.
- With `wr_ack` tied high, a full sequence takes 6 cycles.

## Configuration
- `DAY_LIMIT_EN` defined:
  - The day max depends on month: 31 or 30, and February 28, or 29 when year%4==0.
  - Any change to month or year that leaves day above the new max clamps day to that max in the same update.
  - `btn_up` wraps day from the month max to 1.
- `DAY_LIMIT_EN` undefined: day range is 1..31 for every month, with no clamping.

## Test plan
- Reset: release `rst_n` → `number`=0, `field`=0, `wr_req`=0, `busy`=0. Press `btn_right` ×3 → `field`=3, `number`=1.
- Wrap: in EDIT, field hour at 23, `btn_up` → 0; `btn_down` → 23. Field 0, `btn_left` → `field`=5.
- Commit handshake:
  - Set sec=7, min=30, hour=12, day=15, month=6, year=24.
  - Pulse `commit`; ack each request after 2 wait cycles.
  - Required: 6 requests with `number` = 7, 30, 12, 15, 6, 24 in order; `busy` low after the last ack; buttons ignored throughout.
- Priority: `commit` and `btn_up` in the same cycle → value unchanged, write starts. `btn_up` and `btn_down` together → no change.
- Reset mid-write: assert `rst_n` low during field 2 → all outputs return to reset values at once.
- `DAY_LIMIT_EN`, two cases:
  - day=31, month=1, `btn_up` on month → month 2, day 29 (year 0).
  - year 1 with month 2 → day max 28, and `btn_up` at 28 → 1.
  - Without the macro: month 2 → day stays 31.
